// File: rtl/bus_mem_if.sv
// Valid/ready memory bus between the core-side arbiter (master) and a memory responder (slave).
// The initiator holds valid/addr/wdata/wstrb until it sees the one-cycle ready pulse.
interface bus_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/bus_mem.sv
// Memory-side bus responder: byte-strobed word RAM, LED register, free-running cycle counter,
// configurable response latency and a sticky out-of-range error flag.
module bus_mem #(
    parameter int          WORDS     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    bus_mem_if.slave    bus,
    output logic [7:0]  leds,
    output logic        bus_err
);
    localparam int          AW        = $clog2(WORDS);
    localparam logic [31:0] RAM_MASK  = ~(32'(4 * WORDS) - 32'd1);
    localparam logic [3:0]  WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [2:0] {K_RAM, K_LED, K_CNT, K_RSV, K_ERR} kind_t;

    state_t         state, state_next;
    logic [3:0]     wcnt, wcnt_next;
    logic [31:0]    ram [WORDS];
    logic [31:0]    cycle_cnt;
    logic [31:0]    rdata_q;
    logic [31:0]    rd_mux;
    kind_t          dec_kind, req_kind, cur_kind;
    logic [AW-1:0]  dec_idx, req_idx, cur_idx;
    logic           req_write, cur_write;
    logic           accept, enter_resp;
    logic           unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.mem_addr[1:0];

    // Live decode of the presented address; only consulted at the acceptance edge.
    always_comb begin
        dec_kind = K_ERR;
        dec_idx  = bus.mem_addr[AW+1:2];
        if ((bus.mem_addr & RAM_MASK) == RAM_BASE) begin
            dec_kind = K_RAM;
        end else if (bus.mem_addr[31:4] == MMIO_BASE[31:4]) begin
            unique case (bus.mem_addr[3:2])
                2'd0:    dec_kind = K_LED;
                2'd1:    dec_kind = K_CNT;
                default: dec_kind = K_RSV;
            endcase
        end
    end

    assign accept = (state == IDLE) && bus.mem_valid && !rst;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        unique case (state)
            IDLE: if (bus.mem_valid) begin
                if (LATENCY == 1) begin
                    state_next = RESP;
                end else begin
                    wcnt_next  = WAIT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: if (wcnt == 4'd0) state_next = RESP;
                  else              wcnt_next  = wcnt - 4'd1;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state-holding logic uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_kind  <= K_ERR;
            req_idx   <= '0;
            req_write <= 1'b0;
        end else if (accept) begin
            req_kind  <= dec_kind;
            req_idx   <= dec_idx;
            req_write <= |bus.mem_wstrb;
        end
    end

    // With LATENCY=1 the response is captured on the acceptance edge, so use the live request then.
    assign cur_kind  = (state == IDLE) ? dec_kind         : req_kind;
    assign cur_idx   = (state == IDLE) ? dec_idx          : req_idx;
    assign cur_write = (state == IDLE) ? |bus.mem_wstrb   : req_write;

    always_comb begin
        rd_mux = 32'd0;
        if (!cur_write) begin
            unique case (cur_kind)
                K_RAM:   rd_mux = ram[cur_idx];
                K_LED:   rd_mux = {24'd0, leds};
                K_CNT:   rd_mux = cycle_cnt;
                default: rd_mux = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds      <= 8'd0;
            bus_err   <= 1'b0;
            cycle_cnt <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (enter_resp) rdata_q <= rd_mux;
            if (accept) begin
                if (dec_kind == K_ERR) bus_err <= 1'b1;
                if (dec_kind == K_LED && bus.mem_wstrb[0]) leds <= bus.mem_wdata[7:0];
            end
        end
    end

    // NOTE: the RAM array has no reset; contents survive rst and it maps onto plain memory.
    always_ff @(posedge clk) begin
        if (accept && dec_kind == K_RAM) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstrb[b]) ram[dec_idx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end

    assign bus.mem_ready = (state == RESP);
    assign bus.mem_rdata = rdata_q;
endmodule
